pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage ARM pipeline (IF/ID/EX/MEM/WB).
//  - Drives the PC enable, the IF/ID enable and flush, and the control-signal NOP mux select S.
//  - Tracks in-flight destination registers in EX/MEM/WB and generates operand forwarding selects.
//  - Inserts load-use bubbles, flushes IF/ID on taken branches and freezes the pipe on memory wait.
// PARAMETERS
//  REG_W  4   register index width (R0..R15)
//  CNT_W  16  width of the stall and flush event counters
// PORTS
//  clk           in   1      pipeline clock, rising edge
//  reset         in   1      asynchronous, active-low reset
//  id_rn         in   REG_W  ID-stage first source register
//  id_rm         in   REG_W  ID-stage second source register
//  id_rs         in   REG_W  ID-stage third source (store data / shift reg)
//  id_use_rn     in   1      id_rn is read by the ID instruction
//  id_use_rm     in   1      id_rm is read
//  id_use_rs     in   1      id_rs is read
//  id_rd         in   REG_W  ID-stage destination register
//  id_rf_e       in   1      ID instruction writes the register file (RF_E)
//  id_load       in   1      ID instruction is a load (ID_LOAD)
//  id_br_taken   in   1      branch/BL in ID resolved taken this cycle
//  mem_busy      in   1      data memory not ready; whole pipe must hold
//  enable_pc     out  1      PC register load enable
//  enable_ifid   out  1      IF/ID register load enable
//  ifid_flush    out  1      clear IF/ID to NOP on next edge
//  S             out  1      1 = mux drives NOP (all zeros) into ID/EX controls
//  fwd_a         out  2      source for rn: 00 RF, 01 EX, 10 MEM, 11 WB
//  fwd_b         out  2      source for rm, same encoding
//  fwd_c         out  2      source for rs, same encoding
//  stall_cnt     out  CNT_W  number of load-use bubbles inserted, saturating
//  flush_cnt     out  CNT_W  number of IF/ID flushes, saturating
// BEHAVIOUR
//  - Reset (reset=0, async): all tracking valid bits=0.
//    Outputs: enable_pc=0, enable_ifid=0, ifid_flush=0, S=1, fwd_*=00, counters=0.
//  - Tracking regs ex/mem/wb each hold {rd, rf_e, load}; updated on posedge clk.
//    Per edge: wb<=mem; mem<=ex; ex<=ID info, or invalid (rf_e=0, load=0) if S=1.
//  - Forwarding (combinational, zero latency) for each used source X:
//    first match in priority EX(01) > MEM(10) > WB(11), else 00.
//    Match requires stage rf_e=1 and rd==X. X==R15 always gives 00. Unused source gives 00.
//  - Load-use hazard: ex.load & ex.rf_e & ex.rd matches any used, non-R15 source.
//  - FSM states RUN, FREEZE (registered):
//    RUN, mem_busy=1            -> FREEZE.
//    RUN, load-use              -> stay RUN. This cycle: enable_pc=0, enable_ifid=0, S=1; stall_cnt++.
//    RUN, id_br_taken, no LU    -> ifid_flush=1 one cycle; enable_pc=1; flush_cnt++.
//    RUN, otherwise             -> enable_pc=1, enable_ifid=1, S=0, ifid_flush=0.
//    FREEZE                     -> enable_pc=0, enable_ifid=0, S=0, ifid_flush=0.
//      Tracking regs and counters hold; return to RUN on first edge with mem_busy=0.
//  - Priority: mem_busy > load-use > branch flush.
//    A branch stalled by load-use is not flushed; it re-evaluates the next cycle.
//  - After one bubble the load sits in MEM: fwd selects 10, no second stall.
//  - Counters saturate at all-ones; never wrap.
//  - Reset mid-stall or mid-freeze: immediate reset values; FSM returns to RUN after release.
// TESTING
//  1 LDR R2,[R1]; ADD R5,R2,R3 -> one cycle enable_pc=0, enable_ifid=0, S=1.
//    Next cycle fwd_a=10, S=0; stall_cnt=1.
//  2 ADD R5,R1,R2; SUB R6,R5,R1 -> fwd_a=01 on SUB in ID, no stall, stall_cnt=0.
//  3 R5 written by three consecutive ADDs; then ORR R7,R5,R5 -> fwd_a=fwd_b=01 (EX wins over MEM/WB).
//  4 id_br_taken=1 -> ifid_flush=1 one cycle, flush_cnt=1.
//    With load-use in the same cycle -> stall only, flush_cnt=0.
//  5 mem_busy=1 for 3 cycles -> enables 0, S=0, fwd_* and counters unchanged; resumes RUN on 4th edge.
//  6 reset=0 during a load-use stall -> S=1, enables 0, counters 0 without a clock edge.
//    After release: first ADD R5,R2,R3 gives fwd_a=00, no stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage pipeline: forwarding selects,
// load-use bubbles, taken-branch IF/ID flushes and whole-pipe freeze on memory wait.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rs,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rf_e,
  input  logic             id_load,
  input  logic             id_br_taken,
  input  logic             mem_busy,
  output logic             enable_pc,
  output logic             enable_ifid,
  output logic             ifid_flush,
  output logic             S,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {StRun, StFreeze} state_e;

  localparam logic [REG_W-1:0] PcReg = '1;

  state_e           state_q, state_d;
  logic [REG_W-1:0] ex_rd_q, mem_rd_q, wb_rd_q;
  logic             ex_rfe_q, mem_rfe_q, wb_rfe_q;
  logic             ex_ld_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, frozen;

  // Only the EX-stage load flag matters: one bubble moves the load to MEM where it forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src, input logic use_src,
                                         input logic [REG_W-1:0] ex_rd, input logic ex_v,
                                         input logic [REG_W-1:0] mem_rd, input logic mem_v,
                                         input logic [REG_W-1:0] wb_rd, input logic wb_v);
    if (!use_src || src == PcReg) return 2'b00;
    if (ex_v && ex_rd == src)     return 2'b01;
    if (mem_v && mem_rd == src)   return 2'b10;
    if (wb_v && wb_rd == src)     return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic lu_hit(input logic [REG_W-1:0] src, input logic use_src,
                                  input logic [REG_W-1:0] ex_rd, input logic ex_ldv);
    return use_src && (src != PcReg) && ex_ldv && (ex_rd == src);
  endfunction

  always_comb begin
    fwd_a = fwd_sel(id_rn, id_use_rn, ex_rd_q, ex_rfe_q, mem_rd_q, mem_rfe_q, wb_rd_q, wb_rfe_q);
    fwd_b = fwd_sel(id_rm, id_use_rm, ex_rd_q, ex_rfe_q, mem_rd_q, mem_rfe_q, wb_rd_q, wb_rfe_q);
    fwd_c = fwd_sel(id_rs, id_use_rs, ex_rd_q, ex_rfe_q, mem_rd_q, mem_rfe_q, wb_rd_q, wb_rfe_q);
    load_use = lu_hit(id_rn, id_use_rn, ex_rd_q, ex_ld_q & ex_rfe_q) |
               lu_hit(id_rm, id_use_rm, ex_rd_q, ex_ld_q & ex_rfe_q) |
               lu_hit(id_rs, id_use_rs, ex_rd_q, ex_ld_q & ex_rfe_q);
    // The cycle mem_busy rises already holds the pipe, not just the following ones.
    frozen  = (state_q == StFreeze) || mem_busy;
    state_d = mem_busy ? StFreeze : StRun;

    enable_pc   = 1'b0;
    enable_ifid = 1'b0;
    ifid_flush  = 1'b0;
    S           = 1'b1;
    if (!reset) begin
      S = 1'b1;
    end else if (frozen) begin
      S = 1'b0;
    end else if (!load_use) begin
      enable_pc   = 1'b1;
      enable_ifid = 1'b1;
      S           = 1'b0;
      ifid_flush  = id_br_taken;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StRun;
      ex_rd_q     <= '0;
      mem_rd_q    <= '0;
      wb_rd_q     <= '0;
      ex_rfe_q    <= 1'b0;
      mem_rfe_q   <= 1'b0;
      wb_rfe_q    <= 1'b0;
      ex_ld_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (!frozen) begin
        wb_rd_q   <= mem_rd_q;
        wb_rfe_q  <= mem_rfe_q;
        mem_rd_q  <= ex_rd_q;
        mem_rfe_q <= ex_rfe_q;
        ex_rd_q   <= id_rd;
        ex_rfe_q  <= S ? 1'b0 : id_rf_e;
        ex_ld_q   <= S ? 1'b0 : id_load;
        if (load_use && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        if (!load_use && id_br_taken && flush_cnt_q != '1) begin
          flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed pipeline scenarios plus randomized traffic,
// all outputs compared every cycle against an in-bench in-flight-instruction model.
module tb_pipeline_hazard_ctrl;

  localparam int CntW   = 4;
  localparam int CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      id_rn = '0, id_rm = '0, id_rs = '0, id_rd = '0;
  logic            id_use_rn = 1'b0, id_use_rm = 1'b0, id_use_rs = 1'b0;
  logic            id_rf_e = 1'b0, id_load = 1'b0, id_br_taken = 1'b0, mem_busy = 1'b0;
  logic            enable_pc, enable_ifid, ifid_flush, S;
  logic [1:0]      fwd_a, fwd_b, fwd_c;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.REG_W(4), .CNT_W(CntW)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
    .id_rd(id_rd), .id_rf_e(id_rf_e), .id_load(id_load),
    .id_br_taken(id_br_taken), .mem_busy(mem_busy),
    .enable_pc(enable_pc), .enable_ifid(enable_ifid), .ifid_flush(ifid_flush), .S(S),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Model: list of instructions in flight, index 0 = EX, 1 = MEM, 2 = WB.
  int m_rd[3];
  bit m_wr[3];
  bit m_ld[3];
  bit m_busy_last;
  int m_stall, m_flush;

  typedef struct packed {
    logic       en_pc, en_ifid, flush, s;
    logic [1:0] fa, fb, fc;
    logic       lu, frozen;
  } exp_t;

  function automatic logic [1:0] m_src(int r, bit used);
    if (!used || r == 15) return 2'd0;
    for (int i = 0; i < 3; i++) if (m_wr[i] && m_rd[i] == r) return 2'(i + 1);
    return 2'd0;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   srcs[3];
    bit   used[3];
    srcs = '{int'(id_rn), int'(id_rm), int'(id_rs)};
    used = '{id_use_rn, id_use_rm, id_use_rs};
    e = '0;
    e.fa = m_src(srcs[0], used[0]);
    e.fb = m_src(srcs[1], used[1]);
    e.fc = m_src(srcs[2], used[2]);
    for (int i = 0; i < 3; i++)
      if (used[i] && srcs[i] != 15 && m_ld[0] && m_wr[0] && m_rd[0] == srcs[i]) e.lu = 1'b1;
    e.frozen = m_busy_last || mem_busy;
    if (!reset)         e.s = 1'b1;
    else if (e.frozen)  e.s = 1'b0;
    else if (e.lu)      e.s = 1'b1;
    else begin
      e.en_pc = 1'b1; e.en_ifid = 1'b1; e.flush = id_br_taken;
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin m_rd[i] <= 0; m_wr[i] <= 1'b0; m_ld[i] <= 1'b0; end
      m_busy_last <= 1'b0;
      m_stall <= 0;
      m_flush <= 0;
    end else begin
      m_busy_last <= mem_busy;
      if (!model().frozen) begin
        m_rd[2] <= m_rd[1]; m_wr[2] <= m_wr[1]; m_ld[2] <= m_ld[1];
        m_rd[1] <= m_rd[0]; m_wr[1] <= m_wr[0]; m_ld[1] <= m_ld[0];
        m_rd[0] <= int'(id_rd);
        m_wr[0] <= model().lu ? 1'b0 : id_rf_e;
        m_ld[0] <= model().lu ? 1'b0 : id_load;
        if (model().lu) m_stall <= (m_stall < CntMax) ? m_stall + 1 : CntMax;
        else if (id_br_taken) m_flush <= (m_flush < CntMax) ? m_flush + 1 : CntMax;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    e = model();
    chk("enable_pc", int'(enable_pc), int'(e.en_pc));
    chk("enable_ifid", int'(enable_ifid), int'(e.en_ifid));
    chk("ifid_flush", int'(ifid_flush), int'(e.flush));
    chk("S", int'(S), int'(e.s));
    chk("fwd_a", int'(fwd_a), int'(e.fa));
    chk("fwd_b", int'(fwd_b), int'(e.fb));
    chk("fwd_c", int'(fwd_c), int'(e.fc));
    chk("stall_cnt", int'(stall_cnt), m_stall);
    chk("flush_cnt", int'(flush_cnt), m_flush);
  endtask

  task automatic apply(input logic [3:0] rn, rm, rs, input logic urn, urm, urs,
                       input logic [3:0] rd, input logic rfe, ld, br, busy);
    @(negedge clk);
    id_rn = rn; id_rm = rm; id_rs = rs;
    id_use_rn = urn; id_use_rm = urm; id_use_rs = urs;
    id_rd = rd; id_rf_e = rfe; id_load = ld; id_br_taken = br; mem_busy = busy;
    #1 compare_all();
  endtask

  task automatic alu(input logic [3:0] rd, rn, rm, input logic br = 1'b0, busy = 1'b0);
    apply(rn, rm, 4'd0, 1'b1, 1'b1, 1'b0, rd, 1'b1, 1'b0, br, busy);
  endtask

  task automatic ldr(input logic [3:0] rd, rn);
    apply(rn, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic nop(input logic br = 1'b0);
    apply(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, br, 1'b0);
  endtask

  // Asynchronous reset pulse taken mid-cycle, released on the next falling edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 compare_all();
    chk("rst_S", int'(S), 1);
    chk("rst_enable_pc", int'(enable_pc), 0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    chk("rst_flush_cnt", int'(flush_cnt), 0);
    @(negedge clk);
    id_rf_e = 1'b0; id_load = 1'b0; id_br_taken = 1'b0; mem_busy = 1'b0;
    reset = 1'b1;
  endtask

  function automatic logic [3:0] rreg();
    int v;
    v = $urandom_range(0, 4);
    return (v == 4) ? 4'd15 : 4'(v);
  endfunction

  initial begin
    #1 compare_all();
    chk("init_S", int'(S), 1);
    chk("init_enable_ifid", int'(enable_ifid), 0);
    @(negedge clk);
    reset = 1'b1;

    // LDR R2,[R1]; ADD R5,R2,R3 -> one bubble, then forward from MEM.
    ldr(4'd2, 4'd1);
    alu(4'd5, 4'd2, 4'd3);
    chk("t1_stall_pc", int'(enable_pc), 0);
    chk("t1_stall_ifid", int'(enable_ifid), 0);
    chk("t1_stall_S", int'(S), 1);
    alu(4'd5, 4'd2, 4'd3);
    chk("t1_fwd_mem", int'(fwd_a), 2);
    chk("t1_S_run", int'(S), 0);
    chk("t1_stall_cnt", int'(stall_cnt), 1);

    do_reset();
    alu(4'd5, 4'd1, 4'd2);
    alu(4'd6, 4'd5, 4'd1);
    chk("t2_fwd_ex", int'(fwd_a), 1);
    chk("t2_no_stall", int'(enable_pc), 1);
    chk("t2_stall_cnt", int'(stall_cnt), 0);

    do_reset();
    repeat (3) alu(4'd5, 4'd1, 4'd2);
    alu(4'd7, 4'd5, 4'd5);
    chk("t3_fwd_a", int'(fwd_a), 1);
    chk("t3_fwd_b", int'(fwd_b), 1);

    do_reset();
    nop(1'b1);
    chk("t4_flush", int'(ifid_flush), 1);
    nop();
    chk("t4_flush_cnt", int'(flush_cnt), 1);
    chk("t4_flush_once", int'(ifid_flush), 0);
    do_reset();
    ldr(4'd2, 4'd1);
    alu(4'd5, 4'd2, 4'd3, 1'b1);
    chk("t4_lu_no_flush", int'(ifid_flush), 0);
    chk("t4_lu_S", int'(S), 1);
    alu(4'd5, 4'd2, 4'd3, 1'b1);
    chk("t4_lu_flush_cnt", int'(flush_cnt), 0);
    chk("t4_reeval_flush", int'(ifid_flush), 1);

    do_reset();
    alu(4'd5, 4'd1, 4'd2);
    repeat (3) begin
      alu(4'd6, 4'd5, 4'd1, 1'b0, 1'b1);
      chk("t5_busy_pc", int'(enable_pc), 0);
      chk("t5_busy_S", int'(S), 0);
      chk("t5_busy_fwd", int'(fwd_a), 1);
    end
    alu(4'd6, 4'd5, 4'd1);
    chk("t5_still_frozen", int'(enable_ifid), 0);
    alu(4'd6, 4'd5, 4'd1);
    chk("t5_resumed", int'(enable_pc), 1);
    chk("t5_fwd_held", int'(fwd_a), 1);
    chk("t5_stall_cnt", int'(stall_cnt), 0);

    do_reset();
    ldr(4'd2, 4'd1);
    alu(4'd5, 4'd2, 4'd3);
    alu(4'd5, 4'd2, 4'd3);
    ldr(4'd2, 4'd1);
    alu(4'd5, 4'd2, 4'd3);
    chk("t6_pre_cnt", int'(stall_cnt), 1);
    chk("t6_pre_S", int'(S), 1);
    do_reset();
    alu(4'd5, 4'd2, 4'd3);
    chk("t6_fwd_rf", int'(fwd_a), 0);
    chk("t6_no_stall", int'(enable_pc), 1);

    for (int n = 0; n < 4000; n++) begin
      if (n % 700 == 699) do_reset();
      apply(rreg(), rreg(), rreg(), 1'($urandom), 1'($urandom), 1'($urandom), rreg(),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
